// File: rtl/rx_pkg.sv
// ============================================================================
// Module      : rx_pkg
// Description : Shared types and constants for the USB full-speed RX bit path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rx_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ACTIVE   = 3'd1,
        ERR      = 3'd2,
        EOP1     = 3'd3,
        EOP_WAIT = 3'd4
    } rx_dec_state_t;

    // Line states as {D+, D-}
    localparam logic [1:0] LINE_J   = 2'b10;
    localparam logic [1:0] LINE_K   = 2'b01;
    localparam logic [1:0] LINE_SE0 = 2'b00;

    localparam int DEF_CLKS_PER_BIT = 8;
    localparam int DEF_SAMPLE_POINT = 3;
    localparam int DEF_STUFF_LEN    = 6;

    function automatic logic is_rcving(input rx_dec_state_t s);
        return (s == ACTIVE) || (s == ERR);
    endfunction

endpackage

`default_nettype wire

// File: rtl/rx_edge_detect.sv
// ============================================================================
// Module      : rx_edge_detect
// Description : Flags any change of the synchronized D+/D- pair vs last cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rx_edge_detect
    import rx_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic dplus_i,
    input  logic dminus_i,
    output logic line_edge_o
);

    logic prev_dp_q;
    logic prev_dm_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            {prev_dp_q, prev_dm_q} <= LINE_J;
        end else begin
            prev_dp_q <= dplus_i;
            prev_dm_q <= dminus_i;
        end
    end

    assign line_edge_o = (dplus_i != prev_dp_q) || (dminus_i != prev_dm_q);

endmodule

`default_nettype wire

// File: rtl/rx_bit_decode.sv
// ============================================================================
// Module      : rx_bit_decode
// Description : USB FS RX bit recovery: edge-resynced sampling, NRZI decode,
//               bit-unstuffing and SE0 end-of-packet detection.
//               Optional: define RX_STUFF_ERR_EN to flag stuff violations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rx_bit_decode
    import rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int SAMPLE_POINT = DEF_SAMPLE_POINT,
    parameter int STUFF_LEN    = DEF_STUFF_LEN
) (
    input  logic clk,
    input  logic rst,
    input  logic dplus_sync,
    input  logic dminus_sync,
    output logic rx_bit,
    output logic bit_valid,
    output logic eop,
    output logic stuff_err,
    output logic rcving
);

    localparam int               CNT_W   = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_SMP = CNT_W'(SAMPLE_POINT);
    localparam logic [2:0]       ONES_MX = 3'(STUFF_LEN);

    logic             line_edge;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       ones_q, ones_d;
    logic             last_q, last_d;
    rx_dec_state_t    state_q, state_d;
    logic             rx_bit_q, rx_bit_d;
    logic             bit_valid_q, bit_valid_d;
    logic             eop_q, eop_d;
    logic             stuff_err_q, stuff_err_d;

    logic             sample;
    logic             se0;
    logic             level;
    logic             dec_bit;

    rx_edge_detect u_edge (
        .clk         (clk),
        .rst         (rst),
        .dplus_i     (dplus_sync),
        .dminus_i    (dminus_sync),
        .line_edge_o (line_edge)
    );

    // Every line transition realigns the bit clock; otherwise free-run.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (line_edge || (cnt_q == CNT_MAX)) begin
            cnt_d = '0;
        end
    end

    assign sample  = (cnt_q == CNT_SMP);
    assign se0     = ({dplus_sync, dminus_sync} == LINE_SE0);
    assign level   = dplus_sync;
    assign dec_bit = (level == last_q);

    always_comb begin
        state_d     = state_q;
        ones_d      = ones_q;
        last_d      = last_q;
        rx_bit_d    = 1'b0;
        bit_valid_d = 1'b0;
        eop_d       = 1'b0;
        stuff_err_d = 1'b0;
        if (sample) begin
            if (se0) begin
                case (state_q)
                    EOP1: begin
                        eop_d   = 1'b1;
                        state_d = EOP_WAIT;
                    end
                    EOP_WAIT: state_d = EOP_WAIT;
                    default:  state_d = EOP1;
                endcase
            end else begin
                last_d = level;
                case (state_q)
                    IDLE: begin
                        if (!dec_bit) begin
                            bit_valid_d = 1'b1;
                            ones_d      = 3'd0;
                            state_d     = ACTIVE;
                        end
                    end
                    ACTIVE, EOP1: begin
                        state_d = ACTIVE;
                        if (ones_q == ONES_MX) begin
                            // A 0 here is the stuffed bit and is swallowed.
                            ones_d = 3'd0;
                            if (dec_bit) begin
`ifdef RX_STUFF_ERR_EN
                                stuff_err_d = 1'b1;
                                state_d     = ERR;
`else
                                rx_bit_d    = 1'b1;
                                bit_valid_d = 1'b1;
`endif
                            end
                        end else begin
                            rx_bit_d    = dec_bit;
                            bit_valid_d = 1'b1;
                            ones_d      = dec_bit ? (ones_q + 3'd1) : 3'd0;
                        end
                    end
                    EOP_WAIT: begin
                        if ({dplus_sync, dminus_sync} == LINE_J) begin
                            state_d = IDLE;
                            ones_d  = 3'd0;
                            last_d  = 1'b1;
                        end
                    end
                    default: state_d = state_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ones_q      <= 3'd0;
            last_q      <= 1'b1;
            rx_bit_q    <= 1'b0;
            bit_valid_q <= 1'b0;
            eop_q       <= 1'b0;
            stuff_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ones_q      <= ones_d;
            last_q      <= last_d;
            rx_bit_q    <= rx_bit_d;
            bit_valid_q <= bit_valid_d;
            eop_q       <= eop_d;
            stuff_err_q <= stuff_err_d;
        end
    end

    assign rx_bit    = rx_bit_q;
    assign bit_valid = bit_valid_q;
    assign eop       = eop_q;
    assign stuff_err = stuff_err_q;
    assign rcving    = is_rcving(state_q);

endmodule

`default_nettype wire

// File: tb/tb_rx_bit_decode.sv
// ============================================================================
// Module      : tb_rx_bit_decode
// Description : Directed self-checking bench for rx_bit_decode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rx_bit_decode;
    import rx_pkg::*;

    logic clk    = 1'b0;
    logic rst    = 1'b1;
    logic dplus  = 1'b1;
    logic dminus = 1'b0;
    logic rx_bit, bit_valid, eop, stuff_err, rcving;

    int   cyc    = 0;
    int   errors = 0;
    int   checks = 0;
    int   excl   = 0;
    int   serr_n = 0;
    int   last_e = 0;
    logic lvl    = 1'b1;

    int   bv_cyc[$];
    logic bv_bit[$];
    int   eop_cyc[$];
    logic exp_bits[$];

    int   e_sync[8];
    int   e_post;
    int   s_eop;

    rx_bit_decode dut (
        .clk         (clk),
        .rst         (rst),
        .dplus_sync  (dplus),
        .dminus_sync (dminus),
        .rx_bit      (rx_bit),
        .bit_valid   (bit_valid),
        .eop         (eop),
        .stuff_err   (stuff_err),
        .rcving      (rcving)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bit_valid) begin
            bv_cyc.push_back(cyc);
            bv_bit.push_back(rx_bit);
        end
        if (eop) eop_cyc.push_back(cyc);
        if (stuff_err) serr_n++;
        if (int'(bit_valid) + int'(eop) + int'(stuff_err) > 1) excl++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic b, input int n, input logic emit);
        if (!b) lvl = ~lvl;
        last_e = cyc;
        if (emit) exp_bits.push_back(b);
        dplus  = lvl;
        dminus = ~lvl;
        tick(n);
    endtask

    task automatic send_eop();
        dplus  = 1'b0;
        dminus = 1'b0;
        s_eop  = cyc;
        tick(16);
        lvl    = 1'b1;
        dplus  = 1'b1;
        dminus = 1'b0;
        tick(16);
    endtask

    task automatic cmp_bits(input string tag);
        check($sformatf("%s_count", tag), bv_bit.size(), exp_bits.size());
        for (int i = 0; i < bv_bit.size() && i < exp_bits.size(); i++)
            check($sformatf("%s_bit[%0d]", tag, i), 32'(bv_bit[i]), 32'(exp_bits[i]));
    endtask

    task automatic clear_q();
        bv_cyc.delete();
        bv_bit.delete();
        eop_cyc.delete();
        exp_bits.delete();
        serr_n = 0;
    endtask

    task automatic send_sync();
        for (int i = 0; i < 8; i++) begin
            send(i == 7, 8, 1'b1);
            e_sync[i] = last_e;
        end
    endtask

    initial begin
        // Reset and idle
        tick(2);
        rst = 1'b0;
        check("reset_outputs", 32'({rx_bit, bit_valid, eop, stuff_err, rcving}), 32'd0);
        check("reset_state", 32'(dut.state_q), 32'(IDLE));
        tick(40);
        check("idle_no_bits", bv_bit.size(), 0);
        check("idle_no_eop", eop_cyc.size(), 0);
        check("idle_rcving", 32'(rcving), 32'd0);
        check("idle_state", 32'(dut.state_q), 32'(IDLE));
        clear_q();

        // SYNC, stuffed bit, EOP
        send_sync();
        check("sync_rcving", 32'(rcving), 32'd1);
        send(1'b0, 8, 1'b1);
        repeat (6) send(1'b1, 8, 1'b1);
        send(1'b0, 8, 1'b0);
        send(1'b0, 8, 1'b1);
        e_post = last_e;
        send(1'b1, 8, 1'b1);
        send_eop();
        cmp_bits("pkt1");
        for (int i = 0; i < 7; i++)
            if (bv_cyc.size() > i)
                check($sformatf("sync_lat[%0d]", i), bv_cyc[i], e_sync[i] + 5);
        if (bv_cyc.size() > 7) check("sync_last_lat", bv_cyc[7], e_sync[6] + 13);
        if (bv_cyc.size() > 15) check("post_stuff_lat", bv_cyc[15], e_post + 5);
        check("pkt1_no_stuff_err", serr_n, 0);
        check("pkt1_eop_count", eop_cyc.size(), 1);
        if (eop_cyc.size() > 0) check("pkt1_eop_cycle", eop_cyc[0], s_eop + 13);
        check("pkt1_after_rcving", 32'(rcving), 32'd0);
        check("pkt1_after_state", 32'(dut.state_q), 32'(IDLE));
        clear_q();

        // Seven consecutive decoded 1s
        send_sync();
        send(1'b0, 8, 1'b1);
        repeat (6) send(1'b1, 8, 1'b1);
`ifdef RX_STUFF_ERR_EN
        send(1'b1, 8, 1'b0);
        send(1'b0, 8, 1'b0);
        send(1'b1, 8, 1'b0);
        check("viol_state", 32'(dut.state_q), 32'(ERR));
        check("viol_stuff_err", serr_n, 1);
`else
        send(1'b1, 8, 1'b1);
        send(1'b0, 8, 1'b1);
        send(1'b1, 8, 1'b1);
        check("viol_state", 32'(dut.state_q), 32'(ACTIVE));
        check("viol_stuff_err", serr_n, 0);
`endif
        check("viol_rcving", 32'(rcving), 32'd1);
        send_eop();
        cmp_bits("pkt2");
        check("pkt2_eop_count", eop_cyc.size(), 1);
        check("pkt2_after_rcving", 32'(rcving), 32'd0);
        clear_q();

        // Jittered bit lengths
        send(1'b0, 7, 1'b1);
        send(1'b0, 9, 1'b1);
        send(1'b1, 7, 1'b1);
        send(1'b0, 9, 1'b1);
        send(1'b1, 7, 1'b1);
        send(1'b1, 9, 1'b1);
        send(1'b0, 7, 1'b1);
        cmp_bits("jitter");
        check("jitter_rcving", 32'(rcving), 32'd1);
        clear_q();

        // Reset in the cycle whose sample would produce a strobe
        send(1'b0, 4, 1'b0);
        rst = 1'b1;
        tick(1);
        check("midrst_outputs", 32'({rx_bit, bit_valid, eop, stuff_err, rcving}), 32'd0);
        check("midrst_state", 32'(dut.state_q), 32'(IDLE));
        rst    = 1'b0;
        lvl    = 1'b1;
        dplus  = 1'b1;
        dminus = 1'b0;
        tick(20);
        check("midrst_dropped", bv_bit.size(), 0);
        check("midrst_no_eop", eop_cyc.size(), 0);
        check("midrst_rcving", 32'(rcving), 32'd0);

        check("strobes_exclusive", excl, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
